// File: rtl/wshbn_master_block_xfer_if.sv
// Wishbone classic bus plus block request/response channel for wshbn_master_block_xfer.
interface wshbn_master_block_xfer_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
);
  logic [WORD_WIDTH-1:0]             DAT_I;
  logic                              ACK_I;
  logic                              ERR_I;
  logic [ADDR_WIDTH-1:0]             ADR_O;
  logic [WORD_WIDTH-1:0]             DAT_O;
  logic                              WE_O;
  logic                              STB_O;
  logic                              CYC_O;
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_we;
  logic [ADDR_WIDTH-1:0]             req_addr;
  logic [BLOCK_WORDS*WORD_WIDTH-1:0] req_wdata;
  logic                              rsp_valid;
  logic                              rsp_err;
  logic [BLOCK_WORDS*WORD_WIDTH-1:0] rsp_rdata;

  modport master (
    input  DAT_I, ACK_I, ERR_I, req_valid, req_we, req_addr, req_wdata,
    output ADR_O, DAT_O, WE_O, STB_O, CYC_O, req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    output DAT_I, ACK_I, ERR_I, req_valid, req_we, req_addr, req_wdata,
    input  ADR_O, DAT_O, WE_O, STB_O, CYC_O, req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/wshbn_master_block_xfer.sv
// Wishbone classic master moving one cache block per request, with whole-block retry on ERR_I.
// Define WSHBN_MASTER_TIMEOUT_EN to build the bus watchdog (TIMEOUT_CYC stalled cycles act as ERR_I).
module wshbn_master_block_xfer #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int MAX_RETRIES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                       CLK_I,
  input logic                       RST_I,
  wshbn_master_block_xfer_if.master bus
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("wshbn_master_block_xfer: BLOCK_WORDS must be a power of two >= 2, TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {IDLE, XFER, RETRY, DONE, FAIL} state_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             base_q;
  logic                              we_q;
  logic [BLOCK_WORDS*WORD_WIDTH-1:0] wdata_q;
  logic [BLOCK_WORDS*WORD_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [RTY_W-1:0]                  rty_q;
  logic                              accept;
  logic                              word_ack;
  logic                              last_word;
  logic                              timeout_hit;

  assign last_word = (idx_q == '1);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    word_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        // An error (or watchdog expiry) overrides a simultaneous ACK.
        if (bus.ERR_I || timeout_hit) begin
          state_d = (rty_q < RTY_W'(MAX_RETRIES)) ? RETRY : FAIL;
        end else if (bus.ACK_I) begin
          word_ack = 1'b1;
          if (last_word) state_d = DONE;
        end
      end
      RETRY:   state_d = XFER;
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q  <= bus.req_addr & ~ADDR_WIDTH'(BLOCK_WORDS - 1);
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        idx_q   <= '0;
        rty_q   <= '0;
      end
      if (word_ack) begin
        if (!we_q) rdata_q[WORD_WIDTH*int'(idx_q) +: WORD_WIDTH] <= bus.DAT_I;
        if (!last_word) idx_q <= idx_q + IDX_W'(1);
      end
      // Re-issue restarts the block, so partial data from the failed attempt is discarded.
      if (state_q == RETRY) begin
        rty_q   <= rty_q + RTY_W'(1);
        idx_q   <= '0;
        rdata_q <= '0;
      end
    end
  end

`ifdef WSHBN_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_I || state_q != XFER || bus.ACK_I || bus.ERR_I || timeout_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (state_q == XFER) && !bus.ACK_I && !bus.ERR_I &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus.CYC_O     = (state_q == XFER);
  assign bus.STB_O     = (state_q == XFER);
  assign bus.WE_O      = (state_q == XFER) && we_q;
  assign bus.ADR_O     = (state_q == XFER) ? base_q + ADDR_WIDTH'(idx_q) : '0;
  assign bus.DAT_O     = ((state_q == XFER) && we_q) ?
                         wdata_q[WORD_WIDTH*int'(idx_q) +: WORD_WIDTH] : '0;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE) || (state_q == FAIL);
  assign bus.rsp_err   = (state_q == FAIL);
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_wshbn_master_block_xfer.sv
// Directed bench for wshbn_master_block_xfer: a cycle-level slave model driven from tasks.
module tb_wshbn_master_block_xfer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wshbn_master_block_xfer_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WORDS(4)) bus ();

  wshbn_master_block_xfer #(
    .WORD_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WORDS(4), .MAX_RETRIES(2), .TIMEOUT_CYC(8)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // slave behaviour
  int         ws = 0;
  logic [7:0] err_mask = '0;
  int         err_word = 0;
  logic       both_ack = 1'b0;
  logic       silent = 1'b0;
  logic [31:0] rd_words [4];

  // observations from one transaction
  logic [31:0]  adr_log [$];
  logic [31:0]  dat_log [$];
  int           attempts, gaps, we_bad, ready_busy, rsp_cycle;
  logic         rsp_err_seen, ready_after, rsp_after, ready_at_req;
  logic [127:0] rdata_seen, rdata_start;

  localparam logic [127:0] RD_FULL = 128'h000000A3_000000A2_000000A1_000000A0;

  task automatic set_slave(input int w, input logic [7:0] m, input int wd, input logic b, input logic s);
    ws = w; err_mask = m; err_word = wd; both_ack = b; silent = s;
  endtask

  // Caller must be at a negedge. Issues one request, plays the slave, records what it saw.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [127:0] wdata, input int budget);
    int cyc = 0, word = 0, wc = 0;
    logic done = 1'b0, prev_cyc = 1'b0;
    adr_log.delete(); dat_log.delete();
    attempts = 0; gaps = 0; we_bad = 0; ready_busy = 0; rsp_cycle = -1;
    rsp_err_seen = 1'b0; ready_after = 1'b0; rsp_after = 1'b1;
    rdata_seen = 'x; rdata_start = 'x;
    ready_at_req = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.ACK_I = 1'b0; bus.ERR_I = 1'b0; bus.DAT_I = '0;
      if (cyc == 1) rdata_start = bus.rsp_rdata;
      if (bus.req_ready) ready_busy++;
      if (bus.rsp_valid) begin
        rsp_cycle = cyc; rsp_err_seen = bus.rsp_err; rdata_seen = bus.rsp_rdata; done = 1'b1;
      end else if (bus.CYC_O) begin
        if (!prev_cyc) begin attempts++; word = 0; wc = 0; end
        if (bus.WE_O !== we || bus.STB_O !== 1'b1) we_bad++;
        if (!silent) begin
          if (wc < ws) wc++;
          else if (attempts >= 1 && attempts <= 8 && err_mask[attempts-1] && word == err_word) begin
            bus.ERR_I = 1'b1; bus.ACK_I = both_ack; bus.DAT_I = 32'hEE;
          end else begin
            bus.ACK_I = 1'b1; bus.DAT_I = rd_words[word & 3];
            adr_log.push_back(bus.ADR_O); dat_log.push_back(bus.DAT_O);
            word++; wc = 0;
          end
        end
      end else begin
        gaps++;
      end
      prev_cyc = bus.CYC_O;
    end
    if (done) begin
      @(negedge clk);
      ready_after = bus.req_ready;
      rsp_after = bus.rsp_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.CYC_O, bus.STB_O, bus.WE_O} !== 3'b000) begin failures++; $display("FAIL rst_ctl got=%b exp=000", {bus.CYC_O, bus.STB_O, bus.WE_O}); end
    checks++; if ({bus.ADR_O, bus.DAT_O} !== 64'h0) begin failures++; $display("FAIL rst_adr_dat got=%h exp=0", {bus.ADR_O, bus.DAT_O}); end
    checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL rst_rsp got=%b exp=00", {bus.rsp_valid, bus.rsp_err}); end
    checks++; if (bus.rsp_rdata !== 128'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_read();
    set_slave(0, 8'h00, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h103, '0, 100);
    checks++; if (adr_log.size() !== 4) begin failures++; $display("FAIL rd_nacks got=%0d exp=4", adr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (adr_log[i] !== 32'h100 + 32'(i)) begin failures++; $display("FAIL rd_adr%0d got=%h exp=%h", i, adr_log[i], 32'h100 + 32'(i)); end
    end
    checks++; if (dat_log[3] !== 32'h0) begin failures++; $display("FAIL rd_dat_o got=%h exp=0", dat_log[3]); end
    checks++; if (rdata_seen !== RD_FULL) begin failures++; $display("FAIL rd_rdata got=%h exp=%h", rdata_seen, RD_FULL); end
    checks++; if (rsp_cycle !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", rsp_cycle); end
    checks++; if (rsp_err_seen !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", rsp_err_seen); end
    checks++; if (we_bad !== 0) begin failures++; $display("FAIL rd_we_stb got=%0d exp=0", we_bad); end
    checks++; if (ready_busy !== 0) begin failures++; $display("FAIL rd_ready_busy got=%0d exp=0", ready_busy); end
    checks++; if ({ready_after, rsp_after} !== 2'b10) begin failures++; $display("FAIL rd_after got=%b exp=10", {ready_after, rsp_after}); end
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++; if (bus.rsp_rdata !== RD_FULL) begin failures++; $display("FAIL hold_rdata got=%h exp=%h", bus.rsp_rdata, RD_FULL); end
  endtask

  task automatic test_write();
    set_slave(2, 8'h00, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h200, 128'h00000044_00000033_00000022_00000011, 100);
    checks++; if (dat_log.size() !== 4) begin failures++; $display("FAIL wr_nacks got=%0d exp=4", dat_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({adr_log[i], dat_log[i]} !== {32'h200 + 32'(i), 32'h11 * 32'(i + 1)}) begin
        failures++; $display("FAIL wr_pair%0d got=%h/%h exp=%h/%h", i, adr_log[i], dat_log[i], 32'h200 + 32'(i), 32'h11 * 32'(i + 1));
      end
    end
    checks++; if (we_bad !== 0) begin failures++; $display("FAIL wr_we_stb got=%0d exp=0", we_bad); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL wr_stb_gap got=%0d exp=0", gaps); end
    checks++; if (rsp_cycle !== 13) begin failures++; $display("FAIL wr_latency got=%0d exp=13", rsp_cycle); end
    checks++; if (rsp_err_seen !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", rsp_err_seen); end
  endtask

  task automatic test_retry();
    set_slave(0, 8'h01, 2, 1'b0, 1'b0);
    run_txn(1'b0, 32'h100, '0, 100);
    checks++; if (attempts !== 2) begin failures++; $display("FAIL rty_attempts got=%0d exp=2", attempts); end
    checks++; if (gaps !== 1) begin failures++; $display("FAIL rty_cyc_low got=%0d exp=1", gaps); end
    checks++; if (adr_log.size() !== 6) begin failures++; $display("FAIL rty_nacks got=%0d exp=6", adr_log.size()); end
    checks++; if (adr_log[2] !== 32'h100) begin failures++; $display("FAIL rty_restart got=%h exp=100", adr_log[2]); end
    checks++; if (rsp_cycle !== 9) begin failures++; $display("FAIL rty_latency got=%0d exp=9", rsp_cycle); end
    checks++; if ({rsp_err_seen, rdata_seen} !== {1'b0, RD_FULL}) begin failures++; $display("FAIL rty_rsp got=%b/%h exp=0/%h", rsp_err_seen, rdata_seen, RD_FULL); end
  endtask

  task automatic test_fail();
    set_slave(0, 8'h07, 1, 1'b0, 1'b0);
    run_txn(1'b0, 32'h100, '0, 100);
    checks++; if (attempts !== 3) begin failures++; $display("FAIL fail_attempts got=%0d exp=3", attempts); end
    checks++; if (rsp_cycle !== 9) begin failures++; $display("FAIL fail_latency got=%0d exp=9", rsp_cycle); end
    checks++; if (rsp_err_seen !== 1'b1) begin failures++; $display("FAIL fail_err got=%b exp=1", rsp_err_seen); end
    checks++; if (rdata_seen !== 128'h000000A0) begin failures++; $display("FAIL fail_rdata got=%h exp=%h", rdata_seen, 128'h000000A0); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL fail_ready_after got=%b exp=1", ready_after); end
  endtask

  task automatic test_ack_err();
    set_slave(0, 8'h01, 3, 1'b1, 1'b0);
    run_txn(1'b0, 32'h100, '0, 100);
    checks++; if (attempts !== 2) begin failures++; $display("FAIL ackerr_attempts got=%0d exp=2", attempts); end
    checks++; if (adr_log[3] !== 32'h100) begin failures++; $display("FAIL ackerr_restart got=%h exp=100", adr_log[3]); end
    checks++; if (rsp_cycle !== 10) begin failures++; $display("FAIL ackerr_latency got=%0d exp=10", rsp_cycle); end
    checks++; if ({rsp_err_seen, rdata_seen} !== {1'b0, RD_FULL}) begin failures++; $display("FAIL ackerr_rsp got=%b/%h exp=0/%h", rsp_err_seen, rdata_seen, RD_FULL); end
  endtask

  task automatic test_back_to_back();
    set_slave(0, 8'h00, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'hFFFF_FFFF, '0, 100);
    checks++; if (rdata_start !== 128'h0) begin failures++; $display("FAIL b2b_rdata_clr got=%h exp=0", rdata_start); end
    checks++; if ({adr_log[0], adr_log[3]} !== {32'hFFFF_FFFC, 32'hFFFF_FFFF}) begin failures++; $display("FAIL b2b_top_adr got=%h/%h exp=fffffffc/ffffffff", adr_log[0], adr_log[3]); end
    run_txn(1'b1, 32'h41, 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000, 100);
    checks++; if (ready_at_req !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ready_at_req); end
    checks++; if ({adr_log[1], dat_log[1]} !== {32'h41, 32'hBBBB0000}) begin failures++; $display("FAIL b2b_wr got=%h/%h exp=41/bbbb0000", adr_log[1], dat_log[1]); end
    checks++; if (rsp_cycle !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", rsp_cycle); end
  endtask

  task automatic test_reset_midblock();
    set_slave(0, 8'h00, 0, 1'b0, 1'b1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h300; bus.req_wdata = '1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.STB_O !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", bus.STB_O); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus.CYC_O, bus.STB_O, bus.WE_O, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
      failures++; $display("FAIL rstmid_ctl got=%b exp=00000", {bus.CYC_O, bus.STB_O, bus.WE_O, bus.rsp_valid, bus.rsp_err});
    end
    checks++; if ({bus.ADR_O, bus.DAT_O} !== 64'h0) begin failures++; $display("FAIL rstmid_adr_dat got=%h exp=0", {bus.ADR_O, bus.DAT_O}); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%b exp=1", bus.req_ready); end
    @(negedge clk); rst_n = 1'b1;
    silent = 1'b0;
  endtask

  task automatic test_timeout();
    set_slave(0, 8'h00, 0, 1'b0, 1'b1);
`ifdef WSHBN_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h500, '0, 100);
    checks++; if (attempts !== 3) begin failures++; $display("FAIL to_attempts got=%0d exp=3", attempts); end
    checks++; if (gaps !== 2) begin failures++; $display("FAIL to_retries got=%0d exp=2", gaps); end
    checks++; if ({rsp_cycle, rsp_err_seen} !== {32'd27, 1'b1}) begin failures++; $display("FAIL to_fail got=%0d/%b exp=27/1", rsp_cycle, rsp_err_seen); end
`else
    run_txn(1'b0, 32'h500, '0, 60);
    checks++; if (rsp_cycle !== -1) begin failures++; $display("FAIL nowd_rsp got=%0d exp=-1", rsp_cycle); end
    checks++; if ({attempts, bus.STB_O} !== {32'd1, 1'b1}) begin failures++; $display("FAIL nowd_wait got=%0d/%b exp=1/1", attempts, bus.STB_O); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
`endif
    silent = 1'b0;
  endtask

  initial begin
    bus.DAT_I = '0; bus.ACK_I = 1'b0; bus.ERR_I = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rd_words[0] = 32'hA0; rd_words[1] = 32'hA1; rd_words[2] = 32'hA2; rd_words[3] = 32'hA3;
    test_reset();
    test_read();
    test_hold();
    test_write();
    test_retry();
    test_fail();
    test_ack_err();
    test_back_to_back();
    test_reset_midblock();
    test_timeout();
    test_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
